// File: rtl/icache_fetch_responder_if.sv
// Fetch-side and instruction-memory-side signal bundle for the instruction cache.
// Latency: none, wiring only.
// Backpressure: BUSYWAIT stalls the PC logic, MEM_BUSYWAIT stalls the cache fill.
interface icache_fetch_responder_if #(
  parameter int ADDR_W     = 6,
  parameter int MISS_CNT_W = 16
);
  logic [31:0]           PC;
  logic [31:0]           INSTRUCTION;
  logic                  BUSYWAIT;
  logic                  MEM_READ;
  logic [ADDR_W-1:0]     MEM_ADDRESS;
  logic [127:0]          MEM_READDATA;
  logic                  MEM_BUSYWAIT;
  logic [MISS_CNT_W-1:0] MISS_COUNT;

  // The cache itself.
  modport slave (
    input  PC, MEM_READDATA, MEM_BUSYWAIT,
    output INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS, MISS_COUNT
  );

  // PC logic plus instruction memory, seen as one agent.
  modport master (
    output PC, MEM_READDATA, MEM_BUSYWAIT,
    input  INSTRUCTION, BUSYWAIT, MEM_READ, MEM_ADDRESS, MISS_COUNT
  );
endinterface

// File: rtl/icache_fetch_responder.sv
// Direct-mapped read-only instruction cache returning the 32-bit word at PC.
// Latency: hit 0 cycles (combinational); miss = memory latency + 2 cycles.
// Backpressure: BUSYWAIT holds the PC until the word is ready; the fill waits on MEM_BUSYWAIT.
module icache_fetch_responder #(
  parameter int INDEX_BITS = 3,
  parameter int TAG_BITS   = 3,
  parameter int MISS_CNT_W = 16
) (
  input logic                     CLK,
  input logic                     RESET,
  icache_fetch_responder_if.slave bus
);

  localparam int LINES  = 1 << INDEX_BITS;
  localparam int ADDR_W = TAG_BITS + INDEX_BITS;
  localparam int PC_HI  = 4 + INDEX_BITS + TAG_BITS;  // lowest PC bit above the tag

  typedef enum logic [1:0] {
    S_IDLE,
    S_MEM_READ,
    S_UPDATE
  } state_t;

  state_t state_q, state_d;

  // Line storage: valid bits are reset, tag/data are only meaningful when valid.
  logic [LINES-1:0]      valid_q;
  logic [TAG_BITS-1:0]   tag_q  [LINES];
  logic [127:0]          data_q [LINES];

  // Fill bookkeeping.
  logic [ADDR_W-1:0]     fill_addr_q;
  logic [127:0]          fill_data_q;
  logic [MISS_CNT_W-1:0] miss_cnt_q;

  // PC decode.
  logic [1:0]            pc_word;
  logic [INDEX_BITS-1:0] pc_index;
  logic [TAG_BITS-1:0]   pc_tag;
  logic [127:0]          hit_line;
  logic                  hit;
  logic [INDEX_BITS-1:0] fill_index;
  logic [TAG_BITS-1:0]   fill_tag;
  logic                  unused_pc;

  // Combinational outputs.
  logic                  busy;
  logic                  mem_read;
  logic [31:0]           instr;
  logic                  miss_now;

  assign pc_word    = bus.PC[3:2];
  assign pc_index   = bus.PC[4 +: INDEX_BITS];
  assign pc_tag     = bus.PC[4 + INDEX_BITS +: TAG_BITS];
  assign unused_pc  = ^{bus.PC[31:PC_HI], bus.PC[1:0]};

  assign fill_index = fill_addr_q[INDEX_BITS-1:0];
  assign fill_tag   = fill_addr_q[INDEX_BITS +: TAG_BITS];

  assign hit_line   = data_q[pc_index];
  assign hit        = valid_q[pc_index] && (tag_q[pc_index] == pc_tag);
  assign miss_now   = (state_q == S_IDLE) && !hit;

  // Next-state and handshake outputs; instruction is forced to 0 unless a hit is served.
  always_comb begin
    state_d  = state_q;
    busy     = 1'b1;
    mem_read = 1'b0;
    instr    = 32'h0;
    case (state_q)
      S_IDLE: begin
        if (hit) begin
          busy  = 1'b0;
          instr = hit_line[{pc_word, 5'b0} +: 32];
        end else begin
          state_d = S_MEM_READ;
        end
      end
      S_MEM_READ: begin
        mem_read = 1'b1;
        if (!bus.MEM_BUSYWAIT) begin
          state_d = S_UPDATE;
        end
      end
      S_UPDATE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    if (RESET) begin
      busy  = 1'b1;
      instr = 32'h0;
    end
  end

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Latch the missing block address, count misses (saturating) and capture returned data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      fill_addr_q <= '0;
      miss_cnt_q  <= '0;
      fill_data_q <= '0;
    end else begin
      if (miss_now) begin
        fill_addr_q <= {pc_tag, pc_index};
        if (miss_cnt_q != {MISS_CNT_W{1'b1}}) begin
          miss_cnt_q <= miss_cnt_q + {{(MISS_CNT_W-1){1'b0}}, 1'b1};
        end
      end
      if ((state_q == S_MEM_READ) && !bus.MEM_BUSYWAIT) begin
        fill_data_q <= bus.MEM_READDATA;
      end
    end
  end

  // Valid bits: cleared by reset, set when a fill lands.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      valid_q <= '0;
    end else if (state_q == S_UPDATE) begin
      valid_q[fill_index] <= 1'b1;
    end
  end

  // Tag and data write for the line being filled; a reset abandons the write.
  always_ff @(posedge CLK) begin
    if (!RESET && (state_q == S_UPDATE)) begin
      tag_q[fill_index]  <= fill_tag;
      data_q[fill_index] <= fill_data_q;
    end
  end

  assign bus.BUSYWAIT    = busy;
  assign bus.INSTRUCTION = instr;
  assign bus.MEM_READ    = mem_read;
  assign bus.MEM_ADDRESS = fill_addr_q;
  assign bus.MISS_COUNT  = miss_cnt_q;

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Self-checking bench for icache_fetch_responder with a latency-programmable memory model.
// Latency: checks 0-cycle hits and (memory latency + 2)-cycle misses as seen at negedge samples.
// Backpressure: the memory model holds MEM_BUSYWAIT for mem_lat cycles of every request.
module tb_icache_fetch_responder;

  logic clk;
  logic rst;
  logic rst_s;

  icache_fetch_responder_if #(.ADDR_W(6), .MISS_CNT_W(16)) bus ();
  icache_fetch_responder_if #(.ADDR_W(6), .MISS_CNT_W(4))  bus_s ();

  icache_fetch_responder #(.INDEX_BITS(3), .TAG_BITS(3), .MISS_CNT_W(16)) dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  // Narrow-counter instance so saturation is reachable in a short run.
  icache_fetch_responder #(.INDEX_BITS(3), .TAG_BITS(3), .MISS_CNT_W(4)) dut_sat (
    .CLK   (clk),
    .RESET (rst_s),
    .bus   (bus_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int mem_lat = 5;
  int req_cnt = 0;
  int exp_req = 0;

  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Memory image: block b, word w = (b << 8) | 0x11*(w+1); block 0 = 0x44,0x33,0x22,0x11.
  function automatic logic [31:0] mem_word(input logic [5:0] blk, input logic [1:0] w);
    logic [31:0] b32;
    b32 = {26'h0, blk};
    return (b32 << 8) | (32'h11 * ({30'h0, w} + 32'd1));
  endfunction

  function automatic logic [127:0] mem_block(input logic [5:0] blk);
    return {mem_word(blk, 2'd3), mem_word(blk, 2'd2), mem_word(blk, 2'd1), mem_word(blk, 2'd0)};
  endfunction

  function automatic logic [31:0] exp_instr(input logic [31:0] pc);
    return mem_word(pc[9:4], pc[3:2]);
  endfunction

  task automatic expect_req(input logic [31:0] a);
    exp_addr_q.push_back(a);
    exp_req++;
  endtask

  // Memory model: MEM_BUSYWAIT high for mem_lat cycles of MEM_READ, then data for one cycle.
  initial begin
    int mcnt;
    mcnt = 0;
    bus.MEM_BUSYWAIT = 1'b1;
    bus.MEM_READDATA = '0;
    forever begin
      @(negedge clk);
      if (bus.MEM_READ) begin
        if (mcnt < mem_lat) begin
          bus.MEM_BUSYWAIT = 1'b1;
          mcnt++;
        end else begin
          bus.MEM_BUSYWAIT = 1'b0;
          bus.MEM_READDATA = mem_block(bus.MEM_ADDRESS);
        end
      end else begin
        bus.MEM_BUSYWAIT = 1'b1;
        mcnt = 0;
      end
    end
  end

  // Request monitor: checks each new request address and its stability while MEM_READ holds.
  initial begin
    logic        prev_rd;
    logic [31:0] cur_addr;
    prev_rd  = 1'b0;
    cur_addr = '0;
    forever begin
      @(negedge clk);
      if (bus.MEM_READ && !prev_rd) begin
        req_cnt++;
        cur_addr = {26'h0, bus.MEM_ADDRESS};
        if (exp_addr_q.size() > 0) begin
          chk("req_addr", cur_addr, exp_addr_q.pop_front());
        end
      end else if (bus.MEM_READ) begin
        chk("addr_stable", {26'h0, bus.MEM_ADDRESS}, cur_addr);
      end
      prev_rd = bus.MEM_READ;
    end
  end

  // Drive a PC, wait for BUSYWAIT low, compare against the scoreboard.
  task automatic fetch(input logic [31:0] pc, output int busy_n, output int rd_n);
    bit got;
    got    = 1'b0;
    busy_n = 0;
    rd_n   = 0;
    exp_q.push_back(exp_instr(pc));
    bus.PC = pc;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (bus.MEM_READ) rd_n++;
      if (!bus.BUSYWAIT) begin
        got = 1'b1;
        break;
      end
      busy_n++;
    end
    if (!got) begin
      chk("fetch_timeout", busy_n, 0);
      void'(exp_q.pop_front());
    end else begin
      chk("instr", bus.INSTRUCTION, exp_q.pop_front());
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n;
    int rd_n;
    int req0;
    logic [31:0] pcs[3];

    rst    = 1'b1;
    rst_s  = 1'b1;
    bus.PC = 32'h0;
    bus_s.PC = 32'h0;
    bus_s.MEM_BUSYWAIT = 1'b0;
    bus_s.MEM_READDATA = 128'h0000_0004_0000_0003_0000_0002_0000_0001;

    // Reset state.
    repeat (3) @(negedge clk);
    chk("rst_busywait", {31'h0, bus.BUSYWAIT}, 32'd1);
    chk("rst_instr", bus.INSTRUCTION, 32'h0);
    chk("rst_mem_read", {31'h0, bus.MEM_READ}, 32'd0);
    chk("rst_mem_addr", {26'h0, bus.MEM_ADDRESS}, 32'd0);
    chk("rst_miss_cnt", {16'h0, bus.MISS_COUNT}, 32'd0);

    // Cold miss, latency 5.
    rst = 1'b0;
    mem_lat = 5;
    expect_req(32'd0);
    fetch(32'h0, busy_n, rd_n);
    chk("cold_busy_cycles", busy_n, 32'd7);
    chk("cold_mem_read_cycles", rd_n, 32'd6);
    chk("cold_miss_cnt", {16'h0, bus.MISS_COUNT}, 32'd1);

    // Same-block hits.
    req0 = req_cnt;
    pcs[0] = 32'h4; pcs[1] = 32'h8; pcs[2] = 32'hC;
    foreach (pcs[i]) begin
      fetch(pcs[i], busy_n, rd_n);
      chk("hit_busy_cycles", busy_n, 32'd0);
      chk("hit_mem_read", rd_n, 32'd0);
    end
    chk("hit_no_req", req_cnt, req0);
    chk("hit_miss_cnt", {16'h0, bus.MISS_COUNT}, 32'd1);

    // Conflict eviction on index 0, latency 2.
    mem_lat = 2;
    expect_req(32'b001000);
    fetch(32'h080, busy_n, rd_n);
    chk("evict1_busy_cycles", busy_n, 32'd4);
    expect_req(32'b000000);
    fetch(32'h000, busy_n, rd_n);
    chk("evict2_busy_cycles", busy_n, 32'd4);
    chk("evict_miss_cnt", {16'h0, bus.MISS_COUNT}, 32'd3);

    // PC change mid-fill: line 1 fills first, then line 2 misses.
    mem_lat = 3;
    expect_req(32'd1);
    expect_req(32'd2);
    busy_n = 0;
    bus.PC = 32'h010;
    repeat (2) begin
      @(negedge clk);
      if (bus.BUSYWAIT) busy_n++;
    end
    exp_q.push_back(exp_instr(32'h020));
    bus.PC = 32'h020;
    begin
      bit got;
      got = 1'b0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        if (!bus.BUSYWAIT) begin
          got = 1'b1;
          break;
        end
        busy_n++;
      end
      if (got) chk("redirect_instr", bus.INSTRUCTION, exp_q.pop_front());
      else begin
        chk("redirect_timeout", busy_n, 0);
        void'(exp_q.pop_front());
      end
    end
    chk("redirect_busy_cycles", busy_n, 32'd11);
    fetch(32'h014, busy_n, rd_n);
    chk("line1_hit_busy", busy_n, 32'd0);
    chk("redirect_miss_cnt", {16'h0, bus.MISS_COUNT}, 32'd5);

    // Reset mid-fill abandons the fill and invalidates everything.
    mem_lat = 4;
    expect_req(32'd3);
    bus.PC = 32'h030;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_mem_read", {31'h0, bus.MEM_READ}, 32'd0);
    chk("midrst_miss_cnt", {16'h0, bus.MISS_COUNT}, 32'd0);
    chk("midrst_busywait", {31'h0, bus.BUSYWAIT}, 32'd1);
    chk("midrst_instr", bus.INSTRUCTION, 32'h0);
    rst = 1'b0;
    expect_req(32'd0);
    fetch(32'h000, busy_n, rd_n);
    chk("post_rst_miss_busy", busy_n, 32'd6);
    chk("post_rst_miss_cnt", {16'h0, bus.MISS_COUNT}, 32'd1);

    chk("req_count", req_cnt, exp_req);
    chk("addr_q_left", exp_addr_q.size(), 32'd0);

    // Counter saturation: 2^4+3 alternating conflict misses on the 4-bit instance.
    @(negedge clk);
    rst_s = 1'b0;
    for (int i = 0; i < 19; i++) begin
      bit got;
      got = 1'b0;
      bus_s.PC = (i % 2 == 1) ? 32'h080 : 32'h000;
      for (int c = 0; c < 20; c++) begin
        @(negedge clk);
        if (!bus_s.BUSYWAIT) begin
          got = 1'b1;
          break;
        end
      end
      if (!got) chk("sat_timeout", {31'h0, bus_s.BUSYWAIT}, 32'd0);
      chk("sat_miss_cnt", {28'h0, bus_s.MISS_COUNT}, (i + 1 > 15) ? 32'd15 : 32'(i + 1));
    end
    chk("sat_instr", bus_s.INSTRUCTION, 32'h1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/icache_fetch_responder.md
Name: icache_fetch_responder

Overview:
- Fetch-side responder for the PC update logic.
- Takes the current PC and returns the 32-bit instruction at that address.
- Drives BUSYWAIT high while the instruction is not yet available; the PC logic only advances while BUSYWAIT is low.
- Implemented as a direct-mapped, read-only instruction cache in front of a slow block-wide instruction memory that has its own busywait handshake.

Parameters:
- INDEX_BITS, 3, log2 of the number of cache lines (default 8 lines).
- TAG_BITS, 3, tag width. PC[9:0] is the byte address; PC[31:10] is ignored.
- MISS_CNT_W, 16, width of the saturating miss counter.

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- PC  input  32  fetch address from the PC logic; word aligned, PC[1:0] ignored.
- INSTRUCTION  output  32  instruction word for PC; valid whenever BUSYWAIT=0.
- BUSYWAIT  output  1  high = instruction not ready; PC must hold.
- MEM_READ  output  1  block read request to instruction memory.
- MEM_ADDRESS  output  6  block address {tag, index} for the request.
- MEM_READDATA  input  128  16-byte block from memory; word 0 is in bits [31:0].
- MEM_BUSYWAIT  input  1  memory busy; read data is valid on the first cycle this is low while MEM_READ=1.
- MISS_COUNT  output  MISS_CNT_W  number of misses since reset; saturates at all-ones.

Behaviour:
- Reset is synchronous and active-high; clock is CLK, reset is RESET. Under RESET, on the next rising edge:
  - all valid bits clear; state=IDLE;
  - MEM_READ=0, MEM_ADDRESS=0, MISS_COUNT=0.
- While RESET is high, BUSYWAIT=1 and INSTRUCTION=0.
- Address split: byte offset PC[1:0], word offset PC[3:2], index PC[6:4], tag PC[9:7].
- Each line holds a valid bit, a 3-bit tag and 128 bits of data.
- hit = valid[index] && tag[index]==PC tag. It is evaluated combinationally every cycle in IDLE.
- States:
  - IDLE:
    - On hit: BUSYWAIT=0 and INSTRUCTION = data[index][32*word offset +: 32], same cycle (zero-cycle hit latency).
    - On miss: BUSYWAIT=1 combinationally. At the edge, latch {tag,index} into MEM_ADDRESS, increment MISS_COUNT (saturating) and go to MEM_READ.
  - MEM_READ:
    - MEM_READ=1, BUSYWAIT=1.
    - Stay while MEM_BUSYWAIT=1.
    - On the first edge with MEM_BUSYWAIT=0, capture MEM_READDATA and go to UPDATE.
  - UPDATE (1 cycle):
    - MEM_READ=0, BUSYWAIT=1.
    - Write the data to the line at the latched index, set its tag and valid bit, go to IDLE.
    - The hit is re-evaluated in IDLE, so miss-to-ready latency = memory latency + 2 cycles.
- MEM_ADDRESS is stable for the whole MEM_READ state.
- MEM_READ deasserts on the edge that accepts the data, never earlier.
- A PC change during MEM_READ or UPDATE does not redirect the fill. The latched line is filled, then the new PC is compared in IDLE; this can produce a second miss.
- The cache is read-only: there is no write port and no dirty state, so evictions overwrite without writeback.
- Reset in MEM_READ or UPDATE abandons the fill. No line is written, MEM_READ=0 from the next edge, and all lines are invalid.
- MEM_BUSYWAIT is ignored outside MEM_READ.
- INSTRUCTION is a don't-care while BUSYWAIT=1, but it must never be X after reset.

Test Plan:
- Cold miss:
  - Stimulus: reset, then PC=0x00000000, with memory latency 5 cycles and block 0 = {0x44,0x33,0x22,0x11} (word3..word0).
  - Required: BUSYWAIT=1 for 7 cycles, MEM_ADDRESS=0, MEM_READ high for 6 cycles.
  - Then BUSYWAIT=0 with INSTRUCTION=0x00000011, and MISS_COUNT=1.
- Same-block hits:
  - Stimulus: step PC through 0x4, 0x8, 0xC after the cold miss.
  - Required: BUSYWAIT=0 every cycle; INSTRUCTION=0x22, 0x33, 0x44; MEM_READ never asserts; MISS_COUNT stays 1.
- Conflict eviction:
  - Stimulus: PC=0x080 (same index 0, tag 1), then PC=0x000.
  - Required: two misses; MEM_ADDRESS=6'b001000 then 6'b000000; MISS_COUNT=3; the correct words are returned after each fill.
- PC change mid-fill:
  - Stimulus: miss on PC=0x010, then change PC to 0x020 during MEM_READ.
  - Required: line 1 is filled with MEM_ADDRESS=1, then a second miss occurs with MEM_ADDRESS=2; BUSYWAIT stays high throughout until line 2 is ready.
- Reset mid-fill:
  - Stimulus: assert RESET for 1 cycle in MEM_READ.
  - Required: MEM_READ=0 and MISS_COUNT=0 on the next edge; a subsequent access to any previously cached PC misses.
- Counter saturation:
  - Stimulus: force 2^16+3 alternating conflict misses.
  - Required: MISS_COUNT=0xFFFF and no wrap.
